// File: rtl/ahb_lite_ram_slave.sv
// ahb_lite_ram_slave: AHB-Lite responder backed by a word-organised on-chip RAM
// with a fixed number of data-phase wait states and saturating transfer counters.
//
// Optional feature macro: AHB_RAM_ERROR_RESP_EN
//   defined   : out-of-range address or HSIZE > 2 gives a two-cycle ERROR response
//   undefined : address wraps modulo RAM size, HSIZE > 2 acts as word, HRESP = 0
//
// Ports:
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   HADDR/HSIZE/HWRITE   address-phase controls, captured on accept
//   HSEL/HTRANS/HREADY   accept qualifiers
//   HBURST               ignored (every transfer is single)
//   HWDATA               data-phase write data
//   HRDATA               read data (zero outside a read data phase)
//   HREADYOUT/HRESP      slave ready / response
//   WRCOUNT/RDCOUNT      completed OKAY writes / reads, saturating at 16'hFFFF
module ahb_lite_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [15:0] WRCOUNT,
    output logic [15:0] RDCOUNT
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1
`ifdef AHB_RAM_ERROR_RESP_EN
        ,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
`endif
    } state_e;

    logic [31:0]          mem [DEPTH];

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 wr_q, wr_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [3:0]           lanes_q, lanes_d;
    logic [15:0]          wrcount_q, rdcount_q;

    logic                 ready_s;
    logic                 resp_s;
    logic [31:0]          offset_s;
    logic [3:0]           req_lanes_s;
    logic                 accept_s;
    logic                 addr_err_s;
    logic                 complete_s;
    logic                 unused_ok;

    // Address-phase decode
    assign offset_s = HADDR - BASE_ADDR;
    assign accept_s = HSEL & HTRANS[1] & HREADY & ready_s;

    always_comb begin
        req_lanes_s = 4'b1111;
        case (HSIZE)
            3'd0:    req_lanes_s = 4'(4'b0001 << HADDR[1:0]);
            3'd1:    req_lanes_s = HADDR[1] ? 4'b1100 : 4'b0011;
            default: req_lanes_s = 4'b1111;
        endcase
    end

`ifdef AHB_RAM_ERROR_RESP_EN
    // Offset wraps below BASE_ADDR, so a single unsigned range test suffices
    assign addr_err_s = ((offset_s >> (ADDR_BITS + 2)) != 32'd0) || (HSIZE > 3'd2);
`else
    assign addr_err_s = 1'b0;
`endif

    // Completion: pending op while the slave drives ready
    assign complete_s = pend_q & ready_s;

    // State and data-phase control registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        lanes_d = lanes_q;

        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef AHB_RAM_ERROR_RESP_EN
            ST_ERR1: state_d = ST_ERR2;
`endif
            default: ;
        endcase

        // Any ready cycle ends the current data phase and may open a new one
        if (ready_s) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            if (accept_s) begin
                wr_d    = HWRITE;
                idx_d   = offset_s[ADDR_BITS+1:2];
                lanes_d = req_lanes_s;
                if (addr_err_s) begin
`ifdef AHB_RAM_ERROR_RESP_EN
                    state_d = ST_ERR1;
`endif
                end else if (WAIT_STATES == 0) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d  = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
        end
    end

    // Output decode
    always_comb begin
        ready_s = 1'b1;
        resp_s  = 1'b0;
        case (state_q)
            ST_WAIT: ready_s = 1'b0;
`ifdef AHB_RAM_ERROR_RESP_EN
            ST_ERR1: begin
                ready_s = 1'b0;
                resp_s  = 1'b1;
            end
            ST_ERR2: resp_s = 1'b1;
`endif
            default: ;
        endcase
        HRDATA = (complete_s && !wr_q) ? mem[idx_q] : 32'd0;
    end

    assign HREADYOUT = ready_s;
    assign HRESP     = resp_s;
    assign WRCOUNT   = wrcount_q;
    assign RDCOUNT   = rdcount_q;

    // RAM write port; contents are intentionally not reset
    always_ff @(posedge HCLK) begin
        if (complete_s && wr_q) begin
            for (int n = 0; n < 4; n++) begin
                if (lanes_q[n]) begin
                    mem[idx_q][8*n +: 8] <= HWDATA[8*n +: 8];
                end
            end
        end
    end

    // Saturating OKAY-transfer counters
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wrcount_q <= '0;
            rdcount_q <= '0;
        end else if (complete_s) begin
            if (wr_q && (wrcount_q != 16'hFFFF)) begin
                wrcount_q <= wrcount_q + 16'd1;
            end
            if (!wr_q && (rdcount_q != 16'hFFFF)) begin
                rdcount_q <= rdcount_q + 16'd1;
            end
        end
    end

    assign unused_ok = ^{HBURST, HTRANS[0], HSIZE[2], offset_s[31:ADDR_BITS+2], offset_s[1:0]};

endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
// Bench for ahb_lite_ram_slave: two instances (2 wait states, non-zero base;
// zero wait states, base 0) checked against a word-array reference model.
module tb_ahb_lite_ram_slave;

    localparam logic [31:0] BASE0 = 32'h2000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0000;

    logic        hclk;
    logic [1:0]  hresetn;
    logic [31:0] haddr  [2];
    logic [2:0]  hburst;
    logic [1:0]  hsel;
    logic [2:0]  hsize  [2];
    logic [1:0]  htrans [2];
    logic [31:0] hwdata [2];
    logic [1:0]  hwrite;
    logic [1:0]  hready;
    logic [31:0] hrdata [2];
    logic [1:0]  hreadyout;
    logic [1:0]  hresp;
    logic [15:0] wrcount [2];
    logic [15:0] rdcount [2];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] mdl_mem [2][1024];
    int          mdl_wr  [2];
    int          mdl_rd  [2];

    assign hready = hreadyout;

    ahb_lite_ram_slave #(.BASE_ADDR(BASE0), .ADDR_BITS(10), .WAIT_STATES(2)) u_dut0 (
        .HCLK(hclk), .HRESETn(hresetn[0]), .HADDR(haddr[0]), .HBURST(hburst),
        .HSEL(hsel[0]), .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
        .HWRITE(hwrite[0]), .HREADY(hready[0]), .HRDATA(hrdata[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .WRCOUNT(wrcount[0]), .RDCOUNT(rdcount[0])
    );

    ahb_lite_ram_slave #(.BASE_ADDR(BASE1), .ADDR_BITS(10), .WAIT_STATES(0)) u_dut1 (
        .HCLK(hclk), .HRESETn(hresetn[1]), .HADDR(haddr[1]), .HBURST(hburst),
        .HSEL(hsel[1]), .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
        .HWRITE(hwrite[1]), .HREADY(hready[1]), .HRDATA(hrdata[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .WRCOUNT(wrcount[1]), .RDCOUNT(rdcount[1])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Byte-lane merge from the lane rules, little-endian
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] addr,
                                          input logic [2:0] size, input logic [31:0] data);
        logic [31:0] res;
        logic [1:0]  a;
        bit          sel;
        res = old;
        a   = addr[1:0];
        for (int n = 0; n < 4; n++) begin
            if (size == 3'd0)      sel = (n == int'(a));
            else if (size == 3'd1) sel = ((n / 2) == int'(a[1]));
            else                   sel = 1'b1;
            if (sel) res[8*n +: 8] = data[8*n +: 8];
        end
        return res;
    endfunction

    task automatic mdl_xfer(input int d, input bit wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata,
                            output logic [31:0] rdata, output bit err);
        logic [31:0] off;
        int          idx;
        off   = addr - ((d == 0) ? BASE0 : BASE1);
        idx   = int'((off / 32'd4) % 32'd1024);
        err   = 1'b0;
`ifdef AHB_RAM_ERROR_RESP_EN
        err   = (off >= 32'h1000) || (size > 3'd2);
`endif
        rdata = 32'd0;
        if (!err) begin
            if (wr) begin
                mdl_mem[d][idx] = merge(mdl_mem[d][idx], addr, size, wdata);
                if (mdl_wr[d] < 65535) mdl_wr[d]++;
            end else begin
                rdata = mdl_mem[d][idx];
                if (mdl_rd[d] < 65535) mdl_rd[d]++;
            end
        end
    endtask

    // Single non-pipelined transfer; entered and left 1 time unit after a rising edge
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int stalls, output bit resp);
        hburst    = 3'($urandom_range(0, 7));
        haddr[d]  = addr;
        hsize[d]  = size;
        hwrite[d] = wr;
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        @(posedge hclk); #1;
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwdata[d] = wdata;
        haddr[d]  = $urandom;
        stalls    = 0;
        while (!hreadyout[d] && stalls < 40) begin
            stalls++;
            @(posedge hclk); #1;
        end
        n_checks++;
        if (stalls >= 40) $display("FAIL timeout dut%0d: hreadyout stuck low after %0d cycles", d, stalls);
        else n_pass++;
        rdata = hrdata[d];
        resp  = hresp[d];
        @(posedge hclk); #1;
    endtask

    // Transfer checked against the model for latency, response and counters
    task automatic do_xfer(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata, input string tag,
                           output logic [31:0] act, output logic [31:0] exp);
        logic [31:0] r;
        int          st;
        bit          rs;
        bit          err;
        mdl_xfer(d, wr, addr, size, wdata, exp, err);
        xfer(d, wr, addr, size, wdata, r, st, rs);
        act = r;
        check({tag, " stalls"}, 32'(st), err ? 32'd1 : ((d == 0) ? 32'd2 : 32'd0));
        check({tag, " hresp"}, 32'(rs), 32'(err));
        check({tag, " wrcount"}, {16'h0, wrcount[d]}, 32'(mdl_wr[d]));
        check({tag, " rdcount"}, {16'h0, rdcount[d]}, 32'(mdl_rd[d]));
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] off;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] act, exp, a;
        int          sat_start;
        bit          wr;
        logic [2:0]  sz;

        vecs[0] = '{1'b1, 32'h8, 3'd2, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 32'h8, 3'd2, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h4, 3'd2, 32'h1122_3344, 32'h0};
        vecs[3] = '{1'b1, 32'h5, 3'd0, 32'h0000_A500, 32'h0};
        vecs[4] = '{1'b0, 32'h4, 3'd2, 32'h0,         32'h1122_A544};
        vecs[5] = '{1'b1, 32'h6, 3'd1, 32'hBEEF_0000, 32'h0};
        vecs[6] = '{1'b0, 32'h4, 3'd2, 32'h0,         32'hBEEF_A544};

        hresetn = 2'b00;
        hburst  = 3'd0;
        hsel    = 2'b00;
        hwrite  = 2'b00;
        for (int d = 0; d < 2; d++) begin
            haddr[d]  = 32'h0;
            hsize[d]  = 3'd2;
            htrans[d] = 2'b00;
            hwdata[d] = 32'h0;
            mdl_wr[d] = 0;
            mdl_rd[d] = 0;
        end

        // Reset state
        #12;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst dut%0d hreadyout", d), 32'(hreadyout[d]), 32'd1);
            check($sformatf("rst dut%0d hresp", d), 32'(hresp[d]), 32'd0);
            check($sformatf("rst dut%0d hrdata", d), hrdata[d], 32'd0);
            check($sformatf("rst dut%0d wrcount", d), {16'h0, wrcount[d]}, 32'd0);
            check($sformatf("rst dut%0d rdcount", d), {16'h0, rdcount[d]}, 32'd0);
        end
        @(posedge hclk); #1;
        hresetn = 2'b11;
        @(posedge hclk); #1;

        // Directed vectors on the 2-wait-state instance
        for (int i = 0; i < 7; i++) begin
            do_xfer(0, vecs[i].wr, BASE0 + vecs[i].off, vecs[i].size, vecs[i].wdata,
                    $sformatf("vec%0d", i), act, exp);
            check($sformatf("vec%0d hrdata", i), act, vecs[i].exp_rdata);
        end

        // Out-of-range write: error response or wrap to word 0
        do_xfer(0, 1'b1, BASE0, 3'd2, 32'h0BAD_C0DE, "w0 init", act, exp);
        do_xfer(0, 1'b1, BASE0 + 32'h1000, 3'd2, 32'hCAFE_F00D, "oor write", act, exp);
        do_xfer(0, 1'b0, BASE0, 3'd2, 32'h0, "oor readback", act, exp);
`ifdef AHB_RAM_ERROR_RESP_EN
        check("oor word0", act, 32'h0BAD_C0DE);
`else
        check("oor word0", act, 32'hCAFE_F00D);
`endif

        // Reset during the wait of a write discards it
        do_xfer(0, 1'b1, BASE0 + 32'h40, 3'd2, 32'h5555_AAAA, "rst pre", act, exp);
        haddr[0] = BASE0 + 32'h40; hsize[0] = 3'd2; hwrite[0] = 1'b1;
        hsel[0] = 1'b1; htrans[0] = 2'b10;
        @(posedge hclk); #1;
        hsel[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = 32'hFFFF_0000;
        check("wait hreadyout", 32'(hreadyout[0]), 32'd0);
        hresetn[0] = 1'b0;
        #1;
        mdl_wr[0] = 0;
        mdl_rd[0] = 0;
        check("midrst hreadyout", 32'(hreadyout[0]), 32'd1);
        check("midrst hresp", 32'(hresp[0]), 32'd0);
        check("midrst wrcount", {16'h0, wrcount[0]}, 32'd0);
        @(posedge hclk); @(posedge hclk); #1;
        hresetn[0] = 1'b1;
        @(posedge hclk); #1;
        do_xfer(0, 1'b0, BASE0 + 32'h40, 3'd2, 32'h0, "midrst read", act, exp);
        check("midrst old data", act, 32'h5555_AAAA);

        // Randomized traffic on both instances over a 16-word window
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                do_xfer(d, 1'b1, ((d == 0) ? BASE0 : BASE1) + 32'(w * 4), 3'd2, $urandom,
                        $sformatf("init%0d", d), act, exp);
            end
            for (int i = 0; i < 120; i++) begin
                wr = 1'($urandom_range(0, 1));
                sz = 3'($urandom_range(0, 2));
                a  = 32'($urandom_range(0, 63));
                if (sz == 3'd1) a[0] = 1'b0;
                if (sz == 3'd2) a[1:0] = 2'b00;
                a = a + ((d == 0) ? BASE0 : BASE1);
                do_xfer(d, wr, a, sz, $urandom, $sformatf("rnd%0d_%0d", d, i), act, exp);
                check($sformatf("rnd%0d_%0d hrdata", d, i), act, exp);
            end
        end

        // Zero-wait pipelined write then read of the same word
        mdl_xfer(1, 1'b1, BASE1, 3'd2, 32'h1, exp, wr);
        mdl_xfer(1, 1'b0, BASE1, 3'd2, 32'h0, exp, wr);
        haddr[1] = BASE1; hsize[1] = 3'd2; hwrite[1] = 1'b1;
        hsel[1] = 1'b1; htrans[1] = 2'b10;
        @(posedge hclk); #1;
        check("pipe wr ready", 32'(hreadyout[1]), 32'd1);
        check("pipe wr hrdata", hrdata[1], 32'd0);
        hwrite[1] = 1'b0;
        hwdata[1] = 32'h1;
        @(posedge hclk); #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00;
        check("pipe rd ready", 32'(hreadyout[1]), 32'd1);
        check("pipe rd hrdata", hrdata[1], 32'h1);
        @(posedge hclk); #1;
        check("pipe wrcount", {16'h0, wrcount[1]}, 32'(mdl_wr[1]));
        check("pipe rdcount", {16'h0, rdcount[1]}, 32'(mdl_rd[1]));

        // Back-to-back reads until the read counter saturates
        sat_start = mdl_rd[1];
        haddr[1] = BASE1; hsize[1] = 3'd2; hwrite[1] = 1'b0;
        hsel[1] = 1'b1; htrans[1] = 2'b10;
        for (int i = 0; i < 65540; i++) begin
            @(posedge hclk);
            if (i == 999) begin
                #1;
                check("sat midway rdcount", {16'h0, rdcount[1]}, 32'(sat_start + 999));
            end
        end
        #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00;
        check("sat last hrdata", hrdata[1], 32'h1);
        @(posedge hclk); #1;
        for (int i = 0; i < 65540; i++) begin
            if (mdl_rd[1] < 65535) mdl_rd[1]++;
        end
        check("sat rdcount", {16'h0, rdcount[1]}, 32'(mdl_rd[1]));
        check("sat wrcount", {16'h0, wrcount[1]}, 32'(mdl_wr[1]));
        check("sat idle ready", 32'(hreadyout[1]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
